// File: rtl/mem_bank.sv
// mem_bank: single-port word memory with a zeroing sweep after reset and a fixed access latency.
// Define MEM_BANK_BOUNDS_CHECK_EN to flag out-of-range accesses on err.
module mem_bank #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned DEPTH          = 4096,
   parameter int unsigned LATENCY        = 1,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_w,
   output logic [DATA_W-1:0] data_r,
   output logic              rdy,
   output logic              err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = ADDR_W + 1;
   localparam int unsigned CNT_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      StClear = 2'd0,
      StIdle  = 2'd1,
      StBusy  = 2'd2
   } state_e;

   state_e              state_q;
   logic [IDX_W-1:0]    clr_idx_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                op_rd_q;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                in_range;
   logic                mem_we;
   logic [IDX_W-1:0]    mem_idx;
   logic [DATA_W-1:0]   mem_wdata;

   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   assign in_range = {1'b0, addr_q} < CMP_W'(DEPTH);

   // Array write port shared by the clear sweep and write completions; never while rst is high.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = clr_idx_q;
      mem_wdata = '0;
      if (!rst) begin
         unique case (state_q)
            StClear: mem_we = CLEAR_ON_RESET;
            StBusy: begin
               if (cnt_q == '0 && !op_rd_q && in_range) begin
                  mem_we    = 1'b1;
                  mem_idx   = addr_q[IDX_W-1:0];
                  mem_wdata = wdata_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         clr_idx_q <= '0;
         cnt_q     <= '0;
         rdy       <= 1'b0;
         data_r    <= '0;
         err       <= 1'b0;
      end else begin
         unique case (state_q)
            StClear: begin
               if (!CLEAR_ON_RESET || clr_idx_q == LAST_IDX) begin
                  state_q <= StIdle;
                  rdy     <= 1'b1;
               end else begin
                  clr_idx_q <= clr_idx_q + 1'b1;
               end
            end
            StIdle: begin
               if (re || we) begin
                  addr_q  <= address;
                  wdata_q <= data_w;
                  op_rd_q <= re;
                  cnt_q   <= CNT_W'(LATENCY - 1);
                  rdy     <= 1'b0;
                  err     <= 1'b0;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               if (cnt_q == '0) begin
                  if (op_rd_q) begin
                     data_r <= in_range ? mem[addr_q[IDX_W-1:0]] : '0;
                  end
`ifdef MEM_BANK_BOUNDS_CHECK_EN
                  err <= !in_range;
`else
                  err <= 1'b0;
`endif
                  rdy     <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= StClear;
         endcase
      end
   end

endmodule
